reset_seq: RTL and testbench

- Parametrised successor to the single-output reset synchroniser.
- Asserts NUM_OUT reset outputs asynchronously and releases them synchronously, in a fixed order, spaced STEP_CYCLES apart, after the synchroniser delay and an optional hold stretch.
- Adds a synchronous software-reset request, per-output polarity, and status outputs.
- Sits at the top of each clock domain and drives the block resets of that domain in dependency order.

---
 rtl/reset_seq_if.sv | 28 ++
 rtl/reset_seq.sv | 86 ++++++++
 tb/tb_reset_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_if.sv
// Status/control bundle for reset_seq.
//   sw_rst_req : synchronous software request to re-run the reset sequence
//   rst_out    : per-output block resets (polarity set by the sequencer)
//   released   : number of outputs currently released
//   ready      : all outputs released
// slave is the sequencer side, master is the consumer/controller side.
interface reset_seq_if #(
  parameter int unsigned NUM_OUT = 4
) ();
  logic                         sw_rst_req;
  logic [NUM_OUT-1:0]           rst_out;
  logic [$clog2(NUM_OUT+1)-1:0] released;
  logic                         ready;

  modport slave (
    input  sw_rst_req,
    output rst_out,
    output released,
    output ready
  );

  modport master (
    output sw_rst_req,
    input  rst_out,
    input  released,
    input  ready
  );
endinterface

// File: rtl/reset_seq.sv
// Multi-output reset sequencer for one clock domain.
// Asserts every rst_out asynchronously on rst_in, then releases them
// synchronously in index order: bit 0 after SYNC_STAGES+HOLD_CYCLES edges,
// each following bit STEP_CYCLES edges later. A synchronous sw_rst_req
// re-runs the whole sequence.
//   clk    : domain clock
//   rst_in : asynchronous active-high reset from any domain
//   bus    : sw_rst_req in; rst_out, released, ready out (reset_seq_if.slave)
module reset_seq #(
  parameter int unsigned        NUM_OUT     = 4,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter int unsigned        HOLD_CYCLES = 0,
  parameter int unsigned        STEP_CYCLES = 4,
  parameter logic [NUM_OUT-1:0] ACTIVE_HIGH = {NUM_OUT{1'b1}}
) (
  input  logic        clk,
  input  logic        rst_in,
  reset_seq_if.slave  bus
);

  localparam int unsigned TERM = HOLD_CYCLES + (NUM_OUT - 1) * STEP_CYCLES;
  localparam int unsigned CW   = $clog2(TERM + 2);
  localparam int unsigned RW   = $clog2(NUM_OUT + 1);
  // The output flops form the last synchroniser stage, so the chain
  // itself is one stage shorter than SYNC_STAGES.
  localparam int unsigned CL   = SYNC_STAGES - 1;

  logic [CL-1:0]      chain_q, chain_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_OUT-1:0] rel_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic [RW-1:0]      released_q, released_d;
  logic               ready_q, ready_d;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      chain_q    <= '1;
      cnt_q      <= '0;
      out_q      <= ACTIVE_HIGH;
      released_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      released_q <= released_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    chain_d    = '0;
    cnt_d      = cnt_q;
    rel_d      = '0;
    released_d = '0;
    for (int unsigned i = 1; i < CL; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    if (bus.sw_rst_req) begin
      chain_d = '1;
      cnt_d   = '0;
    end else if (!chain_q[CL-1]) begin
      // Counter saturates at TERM and the compare is >=, so releases
      // are monotonic and can never re-assert.
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        rel_d[k] = (32'(cnt_q) >= HOLD_CYCLES + k * STEP_CYCLES);
      end
      if (32'(cnt_q) < TERM) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Polarity applied ahead of the flops so outputs never glitch.
    out_d = ACTIVE_HIGH ^ rel_d;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (rel_d[k]) begin
        released_d = released_d + RW'(1);
      end
    end
    ready_d = rel_d[NUM_OUT-1];
  end

  assign bus.rst_out  = out_q;
  assign bus.released = released_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_reset_seq.sv
module tb_reset_seq;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reset_seq_if #(.NUM_OUT(4)) ifa ();
  reset_seq_if #(.NUM_OUT(3)) ifb ();
  reset_seq_if #(.NUM_OUT(1)) ifc ();

  reset_seq #(
    .NUM_OUT(4), .SYNC_STAGES(2), .HOLD_CYCLES(0), .STEP_CYCLES(4),
    .ACTIVE_HIGH(4'hF)
  ) dut_a (.clk(clk), .rst_in(rst_a), .bus(ifa));

  reset_seq #(
    .NUM_OUT(3), .SYNC_STAGES(3), .HOLD_CYCLES(5), .STEP_CYCLES(1),
    .ACTIVE_HIGH(3'b101)
  ) dut_b (.clk(clk), .rst_in(rst_b), .bus(ifb));

  reset_seq #(
    .NUM_OUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(0), .STEP_CYCLES(1),
    .ACTIVE_HIGH(1'b1)
  ) dut_c (.clk(clk), .rst_in(rst_c), .bus(ifc));

  // Outputs released e edges after the sequence start (e=0: none).
  function automatic int unsigned rel_count(int unsigned e, int unsigned n,
      int unsigned sync, int unsigned hold, int unsigned step);
    int unsigned r;
    if (e < sync + hold) return 0;
    r = (e - sync - hold) / step + 1;
    if (r > n) r = n;
    return r;
  endfunction

  function automatic logic [31:0] exp_out(int unsigned r, int unsigned n,
      logic [31:0] ah);
    logic [31:0] v;
    v = '0;
    for (int unsigned k = 0; k < n; k++) v[k] = (k < r) ? ~ah[k] : ah[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_a(input int unsigned e);
    int unsigned r;
    r = rel_count(e, 4, 2, 0, 4);
    chk($sformatf("a_out_e%0d", e), 32'(ifa.rst_out), exp_out(r, 4, 32'hF));
    chk($sformatf("a_rel_e%0d", e), 32'(ifa.released), r);
    chk($sformatf("a_rdy_e%0d", e), 32'(ifa.ready), 32'(r == 4));
  endtask

  task automatic check_b(input int unsigned e);
    int unsigned r;
    r = rel_count(e, 3, 3, 5, 1);
    chk($sformatf("b_out_e%0d", e), 32'(ifb.rst_out), exp_out(r, 3, 32'h5));
    chk($sformatf("b_rel_e%0d", e), 32'(ifb.released), r);
    chk($sformatf("b_rdy_e%0d", e), 32'(ifb.ready), 32'(r == 3));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a;
    for (int unsigned e = 1; e <= 16; e++) begin
      step();
      check_a(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.sw_rst_req = 1'b0; ifb.sw_rst_req = 1'b0; ifc.sw_rst_req = 1'b0;

    // Asynchronous reset state, before any clock edge.
    #1;
    check_a(0);
    check_b(0);
    chk("c_out_rst", 32'(ifc.rst_out), 32'h1);
    chk("c_rdy_rst", 32'(ifc.ready), 32'h0);

    // Release between edges; next edge is E1.
    @(posedge clk);
    #2;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int unsigned e = 1; e <= 16; e++) begin
      step();
      check_a(e);
      if (e <= 12) check_b(e);
    end

    // Async assert mid-operation while ready.
    step();
    rst_a = 1'b1;
    #1;
    chk("a_async_out", 32'(ifa.rst_out), 32'hF);
    chk("a_async_rdy", 32'(ifa.ready), 32'h0);
    chk("a_async_rel", 32'(ifa.released), 32'h0);
    #2;
    rst_a = 1'b0;
    run_a();

    // Single-cycle software request.
    ifa.sw_rst_req = 1'b1;
    step();
    ifa.sw_rst_req = 1'b0;
    check_a(0);
    run_a();

    // Request held for 5 sampled edges: timing counts from the last one.
    ifa.sw_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_a(0);
    end
    ifa.sw_rst_req = 1'b0;
    run_a();

    // Request landing on E6, where bit 1 would release.
    ifa.sw_rst_req = 1'b1;
    step();
    ifa.sw_rst_req = 1'b0;
    for (int unsigned e = 1; e <= 5; e++) begin
      step();
      check_a(e);
    end
    ifa.sw_rst_req = 1'b1;
    step();
    ifa.sw_rst_req = 1'b0;
    chk("a_sw_e6_out", 32'(ifa.rst_out), 32'hF);
    chk("a_sw_e6_rel", 32'(ifa.released), 32'h0);
    run_a();

    // rst_in dominates a simultaneous software request.
    rst_a = 1'b1;
    ifa.sw_rst_req = 1'b1;
    step();
    chk("a_dom_out", 32'(ifa.rst_out), 32'hF);
    ifa.sw_rst_req = 1'b0;
    #1;
    rst_a = 1'b0;
    run_a();

    // 2 ns pulse with no clock edge inside.
    @(posedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk("a_short_out", 32'(ifa.rst_out), 32'hF);
    chk("a_short_rel", 32'(ifa.released), 32'h0);
    #1;
    rst_a = 1'b0;
    run_a();

    // Single-output compatibility: released exactly after E2.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      rst_c = 1'b1;
      #1;
      chk($sformatf("c_asrt_%0d", i), 32'(ifc.rst_out), 32'h1);
      #1;
      rst_c = 1'b0;
      step();
      chk($sformatf("c_e1_out_%0d", i), 32'(ifc.rst_out), 32'h1);
      chk($sformatf("c_e1_rdy_%0d", i), 32'(ifc.ready), 32'h0);
      step();
      chk($sformatf("c_e2_out_%0d", i), 32'(ifc.rst_out), 32'h0);
      chk($sformatf("c_e2_rel_%0d", i), 32'(ifc.released), 32'h1);
      chk($sformatf("c_e2_rdy_%0d", i), 32'(ifc.ready), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
